pipe_stages: RTL and testbench
==============================

# pipe_stages

Parametrised multi-bit, multi-stage register pipeline with valid/ready flow control. It generalises the single-bit DFF cell into a WIDTH-wide, DEPTH-deep register chain with asynchronous reset, stall propagation, bubble collapsing, an optional skid buffer and synchronous flush. Synthesis flows instantiate it wherever registers are inserted for retiming between combinational cell clusters.

## Interface
- WIDTH, 8, data bits per word (>=1)
- DEPTH, 3, number of pipeline register stages (>=1)
- SKID, 1, 1 = IN_READY is driven from a flop and a one-word skid buffer is added; 0 = IN_READY is combinational from the stage chain
- CK  in  1  clock; all state updates on the rising edge
- RST  in  1  asynchronous, active-high reset
- FLUSH  in  1  synchronous clear of all held words
- IN_VALID  in  1  producer offers D
- IN_READY  out  1  block accepts D this cycle
- D  in  WIDTH  input word
- OUT_VALID  out  1  Q holds a valid word
- OUT_READY  in  1  consumer takes Q this cycle
- Q  out  WIDTH  output word (last stage register)
- OCC  out  clog2(DEPTH+SKID+1)  words currently held

## Operation
- Transfer happens on a rising CK edge when VALID && READY are both high on that interface.
- Stage k (0..DEPTH-1) holds {v[k], d[k]}; stage DEPTH-1 drives OUT_VALID and Q.
- Advance rule: stage k loads from stage k-1 (stage 0 loads from D or the skid) when !v[k] || stage k advances out. The last stage advances out on OUT_READY. Bubbles collapse: an empty stage always accepts even if downstream is stalled.
- SKID=0: IN_READY = !v[0] || stage 0 advances (combinational through the chain).
- SKID=1: IN_READY = !skid_v (registered). If a word is accepted while stage 0 cannot load, it goes to the skid. The skid drains into stage 0 before any new D. IN_READY deasserts the cycle after the skid fills.
- Capacity is DEPTH+SKID words. OCC increments on input transfer, decrements on output transfer, and is unchanged when both occur in the same cycle.
- FLUSH: next edge clears every v[k], skid_v and OCC to 0. An input or output transfer in the same cycle is discarded. FLUSH outranks both.
- Data registers keep their contents on flush. Only valids are cleared.
- Order is strictly preserved. No word is dropped or duplicated except by FLUSH or RST.

## Timing
- Reset values: OUT_VALID=0, Q=0, OCC=0, all v/skid_v=0, all d=0. IN_READY=1 during and after reset for both SKID settings.
- RST asserted mid-transfer: state clears immediately (asynchronous). The transfer in that cycle is lost.
- Latency with no stall: a word accepted at edge t is on Q with OUT_VALID=1 after edge t+DEPTH-1, i.e. visible DEPTH-1 cycles after the accepting edge; DEPTH=1 gives Q valid the cycle after acceptance.
- Throughput: 1 word/cycle sustained while OUT_READY=1, for both SKID settings.
- A full pipe with OUT_READY rising accepts a new word in the same cycle (SKID=0) or one cycle later (SKID=1).
- OUT_VALID never depends combinationally on OUT_READY. Q and OUT_VALID are flop outputs.

## Structure
- Package pipe_pkg: occ_width(depth, skid) constant function; no typedefs needed.
- Sub-module pipe_stage (WIDTH): one valid flop plus data register, with load/clear controls and async RST. It is instantiated DEPTH times in a generate loop; the skid is one more pipe_stage.
- Top level holds the advance logic, the IN_READY mux on SKID, and the OCC counter.

## Test plan
- Reset/latency: WIDTH=8, DEPTH=3, SKID=0. Release RST and send 0x11,0x22,0x33 back-to-back with OUT_READY=1 -> Q=0x11 first valid 2 cycles after its accept edge, then 0x22 and 0x33 on consecutive cycles; OCC peaks at 3.
- Stall fill: OUT_READY=0 with IN_VALID held high -> SKID=0 accepts exactly 3 words, SKID=1 accepts 4; IN_READY then 0 and OCC=DEPTH+SKID. Raise OUT_READY -> words drain in order.
- Bubble collapse: send 0xA5, idle 2 cycles, send 0x5A, OUT_READY=0 -> both words reach the stages adjacent to the output and OCC=2.
- Simultaneous events: full pipe, IN_VALID=1, OUT_READY=1 -> OCC unchanged; the output word leaves and the new word enters (SKID=0 same cycle).
- Flush: OCC=3, then assert FLUSH with IN_VALID=1 -> next cycle OUT_VALID=0, OCC=0, and the input word is not seen later.
- Async reset mid-stream: pulse RST between edges while streaming 0x01..0x08 -> OUT_VALID and Q drop to 0 immediately, IN_READY=1, and OCC=0 before the next edge.

Source files
------------

// File: rtl/pipe_pkg.sv
// ---------------------------------------------------------------------------
// pipe_pkg
//   Shared helpers for the pipe_stages register pipeline.
//
//   occ_width(depth, skid) : bit width needed to count 0..depth+skid held
//                            words, used to size the occupancy port.
// ---------------------------------------------------------------------------
package pipe_pkg;

    // Width of a counter that must represent every value 0..depth+skid.
    function automatic int occ_width(input int depth, input int skid);
        int w;
        w = $clog2(depth + skid + 1);
        return (w < 1) ? 1 : w;
    endfunction

endpackage : pipe_pkg

// File: rtl/pipe_stage.sv
// ---------------------------------------------------------------------------
// pipe_stage
//   One pipeline slot: a valid flop plus a WIDTH-bit data register.
//   Used for every stage of the chain and for the optional skid slot.
//
// Ports
//   ck         : clock, rising edge
//   rst        : asynchronous active-high reset (valid and data to 0)
//   clear      : synchronous clear of the valid flop only (data is kept)
//   load       : slot takes {src_valid, src_data} this edge
//   src_valid  : upstream offers a word (0 = bubble)
//   src_data   : upstream word
//   valid      : slot holds a word
//   data       : held word
// ---------------------------------------------------------------------------
module pipe_stage #(
    parameter int WIDTH = 8
) (
    input  logic             ck,
    input  logic             rst,
    input  logic             clear,
    input  logic             load,
    input  logic             src_valid,
    input  logic [WIDTH-1:0] src_data,
    output logic             valid,
    output logic [WIDTH-1:0] data
);

    // NOTE: sequential state is written only with non-blocking assignments so
    // every slot samples its neighbour's pre-edge value, giving a true shift.
    // NOTE: the data register is reset as well because the pipeline output
    // must read zero after reset, not just be marked invalid.
    always_ff @(posedge ck or posedge rst) begin
        if (rst) begin
            valid <= 1'b0;
            data  <= '0;
        end else if (clear) begin
            // Flush drops the word but leaves the data bits untouched.
            valid <= 1'b0;
        end else if (load) begin
            valid <= src_valid;
            // A bubble moving in keeps the old data; only real words overwrite.
            if (src_valid) begin
                data <= src_data;
            end
        end
    end

endmodule : pipe_stage

// File: rtl/pipe_stages.sv
// ---------------------------------------------------------------------------
// pipe_stages
//   WIDTH-wide, DEPTH-deep register pipeline with valid/ready flow control,
//   stall propagation, bubble collapsing, an optional one-word skid buffer
//   (which makes in_ready a flop output) and a synchronous flush.
//
// Parameters
//   WIDTH : data bits per word (>=1)
//   DEPTH : pipeline register stages (>=1)
//   SKID  : 1 = registered in_ready plus a one-word skid slot,
//           0 = in_ready combinational from the stage chain
//
// Ports
//   ck        : clock, rising edge
//   rst       : asynchronous active-high reset
//   flush     : synchronous clear of every held word (outranks transfers)
//   in_valid  : producer offers d
//   in_ready  : word on d is accepted this cycle
//   d         : input word
//   out_valid : q holds a valid word (flop output)
//   out_ready : consumer takes q this cycle
//   q         : output word (last stage data register)
//   occ       : number of words currently held, 0..DEPTH+SKID
// ---------------------------------------------------------------------------
module pipe_stages
    import pipe_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int DEPTH = 3,
    parameter int SKID  = 1
) (
    input  logic                               ck,
    input  logic                               rst,
    input  logic                               flush,
    input  logic                               in_valid,
    output logic                               in_ready,
    input  logic [WIDTH-1:0]                   d,
    output logic                               out_valid,
    input  logic                               out_ready,
    output logic [WIDTH-1:0]                   q,
    output logic [occ_width(DEPTH, SKID)-1:0]  occ
);

    localparam int OCC_W = occ_width(DEPTH, SKID);

    // Per-stage state and chain control.
    logic [DEPTH-1:0] v;              // stage holds a word
    logic [WIDTH-1:0] dq    [DEPTH];  // stage data
    logic [DEPTH-1:0] take;           // stage loads from its upstream this edge
    logic [DEPTH-1:0] pop;            // stage hands its word downstream this edge
    logic [DEPTH-1:0] src_v;          // upstream valid seen by each stage
    logic [WIDTH-1:0] src_d [DEPTH];  // upstream data seen by each stage

    // Stage 0 feed: either the skid slot or the input port.
    logic             head_v;
    logic [WIDTH-1:0] head_d;

    logic in_fire;
    logic out_fire;

    assign in_fire  = in_valid && in_ready;
    assign out_fire = v[DEPTH-1] && out_ready;

    // ------------------------------------------------------------------
    // Advance logic, evaluated from the output back towards the input.
    // An empty stage always loads, so bubbles collapse even when the
    // stages below it are stalled.
    // ------------------------------------------------------------------
    // NOTE: every signal written in this block gets a default first, so no
    // path through the loop can leave a bit unassigned and infer a latch.
    always_comb begin
        pop  = '0;
        take = '0;
        pop[DEPTH-1]  = v[DEPTH-1] && out_ready;
        take[DEPTH-1] = !v[DEPTH-1] || pop[DEPTH-1];
        for (int k = DEPTH - 2; k >= 0; k--) begin
            pop[k]  = v[k] && take[k+1];
            take[k] = !v[k] || pop[k];
        end
    end

    // Source of each stage: stage 0 from the head feed, others from k-1.
    always_comb begin
        src_v    = '0;
        src_v[0] = head_v;
        src_d[0] = head_d;
        for (int k = 1; k < DEPTH; k++) begin
            src_v[k] = v[k-1];
            src_d[k] = dq[k-1];
        end
    end

    // ------------------------------------------------------------------
    // Stage chain
    // ------------------------------------------------------------------
    for (genvar k = 0; k < DEPTH; k++) begin : g_stage
        pipe_stage #(
            .WIDTH (WIDTH)
        ) u_stage (
            .ck        (ck),
            .rst       (rst),
            .clear     (flush),
            .load      (take[k]),
            .src_valid (src_v[k]),
            .src_data  (src_d[k]),
            .valid     (v[k]),
            .data      (dq[k])
        );
    end

    // ------------------------------------------------------------------
    // Input side: optional skid slot and the in_ready selection.
    // ------------------------------------------------------------------
    if (SKID != 0) begin : g_skid
        logic             skid_v;
        logic [WIDTH-1:0] skid_d;
        logic             skid_fill;
        logic             skid_load;

        // in_ready comes straight from the skid valid flop, so it drops
        // the cycle after the skid captures a word.
        assign in_ready = !skid_v;

        // A word accepted while stage 0 is blocked parks in the skid.
        assign skid_fill = in_fire && !take[0];
        // Load on fill, or load a bubble when the parked word drains.
        assign skid_load = skid_fill || (skid_v && take[0]);

        // The parked word always goes to stage 0 before any new input;
        // while it is parked in_ready is low, so no new word competes.
        assign head_v = skid_v || in_fire;
        assign head_d = skid_v ? skid_d : d;

        pipe_stage #(
            .WIDTH (WIDTH)
        ) u_skid (
            .ck        (ck),
            .rst       (rst),
            .clear     (flush),
            .load      (skid_load),
            .src_valid (skid_fill),
            .src_data  (d),
            .valid     (skid_v),
            .data      (skid_d)
        );
    end else begin : g_no_skid
        // Ready ripples combinationally back from out_ready.
        assign in_ready = take[0];
        assign head_v   = in_fire;
        assign head_d   = d;
    end

    // ------------------------------------------------------------------
    // Occupancy counter: +1 on input transfer, -1 on output transfer,
    // unchanged when both happen; flush discards both and empties it.
    // ------------------------------------------------------------------
    always_ff @(posedge ck or posedge rst) begin
        if (rst) begin
            occ <= '0;
        end else if (flush) begin
            occ <= '0;
        end else if (in_fire && !out_fire) begin
            occ <= occ + OCC_W'(1);
        end else if (!in_fire && out_fire) begin
            occ <= occ - OCC_W'(1);
        end
    end

    // Output is the last stage, both signals straight from flops.
    assign out_valid = v[DEPTH-1];
    assign q         = dq[DEPTH-1];

endmodule : pipe_stages

// File: tb/tb_pipe_stages.sv
// ---------------------------------------------------------------------------
// tb_pipe_stages
//   Drives two pipe_stages instances (SKID=0 and SKID=1, WIDTH=8, DEPTH=3)
//   from the same inputs and compares each against a word-position model:
//   every held word carries the stage index it sits in (-1 = skid slot),
//   the oldest word moves first and each younger word moves up by one
//   unless blocked by the word ahead of it.
// ---------------------------------------------------------------------------
module tb_pipe_stages;

    localparam int WIDTH = 8;
    localparam int DEPTH = 3;
    localparam int MAXW  = 8;

    logic             ck = 1'b0;
    logic             rst;
    logic             flush;
    logic             in_valid;
    logic [WIDTH-1:0] d;
    logic             out_ready;

    logic             iready0, ovalid0;
    logic [WIDTH-1:0] q0;
    logic [1:0]       occ0;
    logic             iready1, ovalid1;
    logic [WIDTH-1:0] q1;
    logic [2:0]       occ1;

    int total = 0;
    int bad   = 0;

    // Reference model state, index 0 = SKID 0, index 1 = SKID 1.
    int             cnt   [2];
    int             pos   [2][MAXW];
    logic [WIDTH-1:0] dat [2][MAXW];
    logic [WIDTH-1:0] q_exp [2];

    always #5 ck = ~ck;

    pipe_stages #(.WIDTH(WIDTH), .DEPTH(DEPTH), .SKID(0)) dut0 (
        .ck(ck), .rst(rst), .flush(flush), .in_valid(in_valid),
        .in_ready(iready0), .d(d), .out_valid(ovalid0),
        .out_ready(out_ready), .q(q0), .occ(occ0)
    );

    pipe_stages #(.WIDTH(WIDTH), .DEPTH(DEPTH), .SKID(1)) dut1 (
        .ck(ck), .rst(rst), .flush(flush), .in_valid(in_valid),
        .in_ready(iready1), .d(d), .out_valid(ovalid1),
        .out_ready(out_ready), .q(q1), .occ(occ1)
    );

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] expv);
        total++;
        assert (obs === expv)
        else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    task automatic model_reset();
        for (int s = 0; s < 2; s++) begin
            cnt[s]   = 0;
            q_exp[s] = '0;
        end
    endtask

    // Lowest position a newly arriving word could take after all held
    // words have moved this edge.
    function automatic int calc_lim(input int s, input bit ordy);
        int lim;
        int np;
        lim = ordy ? DEPTH : DEPTH - 1;
        for (int i = 0; i < cnt[s]; i++) begin
            np  = (pos[s][i] + 1 < lim) ? pos[s][i] + 1 : lim;
            lim = np - 1;
        end
        return lim;
    endfunction

    function automatic bit exp_in_ready(input int s, input bit ordy);
        if (s == 0) return calc_lim(0, ordy) >= 0;
        return (cnt[1] == 0) || (pos[1][cnt[1]-1] != -1);
    endfunction

    function automatic bit exp_out_valid(input int s);
        return (cnt[s] > 0) && (pos[s][0] == DEPTH - 1);
    endfunction

    task automatic model_edge(input int s, input bit iv,
                              input logic [WIDTH-1:0] din,
                              input bit ordy, input bit fl);
        bit               acc;
        int               lim;
        int               np;
        int               n;
        int               tp [MAXW];
        logic [WIDTH-1:0] td [MAXW];
        acc = iv && exp_in_ready(s, ordy);
        n   = 0;
        if (fl) begin
            cnt[s] = 0;
            return;
        end
        lim = ordy ? DEPTH : DEPTH - 1;
        for (int i = 0; i < cnt[s]; i++) begin
            np  = (pos[s][i] + 1 < lim) ? pos[s][i] + 1 : lim;
            lim = np - 1;
            if (np < DEPTH) begin
                if (np == DEPTH - 1 && pos[s][i] != DEPTH - 1) q_exp[s] = dat[s][i];
                tp[n] = np;
                td[n] = dat[s][i];
                n++;
            end
        end
        if (acc) begin
            np = (lim < 0) ? lim : 0;
            if (np == DEPTH - 1) q_exp[s] = din;
            tp[n] = np;
            td[n] = din;
            n++;
        end
        for (int i = 0; i < n; i++) begin
            pos[s][i] = tp[i];
            dat[s][i] = td[i];
        end
        cnt[s] = n;
    endtask

    task automatic check_outputs(input bit ordy);
        check("s0_in_ready",  32'(iready0), 32'(exp_in_ready(0, ordy)));
        check("s0_out_valid", 32'(ovalid0), 32'(exp_out_valid(0)));
        check("s0_q",         32'(q0),      32'(q_exp[0]));
        check("s0_occ",       32'(occ0),    32'(cnt[0]));
        check("s1_in_ready",  32'(iready1), 32'(exp_in_ready(1, ordy)));
        check("s1_out_valid", 32'(ovalid1), 32'(exp_out_valid(1)));
        check("s1_q",         32'(q1),      32'(q_exp[1]));
        check("s1_occ",       32'(occ1),    32'(cnt[1]));
    endtask

    // One clock cycle: drive, check before the edge, advance the model.
    task automatic step(input bit iv, input logic [WIDTH-1:0] din,
                        input bit ordy, input bit fl);
        in_valid  = iv;
        d         = din;
        out_ready = ordy;
        flush     = fl;
        #3;
        check_outputs(ordy);
        @(posedge ck);
        model_edge(0, iv, din, ordy, fl);
        model_edge(1, iv, din, ordy, fl);
        #1;
    endtask

    task automatic drain(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 8'h00, 1'b1, 1'b0);
    endtask

    initial begin
        rst       = 1'b1;
        flush     = 1'b0;
        in_valid  = 1'b0;
        d         = '0;
        out_ready = 1'b0;
        model_reset();

        // Reset state while rst is held.
        #2;
        check_outputs(1'b0);
        @(posedge ck);
        @(posedge ck);
        #1;
        rst = 1'b0;

        // Reset/latency: three back-to-back words, consumer always ready.
        step(1'b1, 8'h11, 1'b1, 1'b0);
        step(1'b1, 8'h22, 1'b1, 1'b0);
        step(1'b1, 8'h33, 1'b1, 1'b0);
        check("lat_q",      32'(q0),      32'h11);
        check("lat_valid",  32'(ovalid0), 32'd1);
        check("lat_occ_pk", 32'(occ0),    32'd3);
        drain(4);

        // Stall fill: consumer stalled, producer always offering.
        for (int i = 0; i < 6; i++) step(1'b1, 8'(8'h40 + i), 1'b0, 1'b0);
        check("fill_occ0",   32'(occ0),    32'd3);
        check("fill_occ1",   32'(occ1),    32'd4);
        check("fill_rdy0",   32'(iready0), 32'd0);
        check("fill_rdy1",   32'(iready1), 32'd0);
        drain(6);

        // Bubble collapse: two words with a gap, consumer stalled.
        step(1'b1, 8'hA5, 1'b0, 1'b0);
        step(1'b0, 8'h00, 1'b0, 1'b0);
        step(1'b0, 8'h00, 1'b0, 1'b0);
        step(1'b1, 8'h5A, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) step(1'b0, 8'h00, 1'b0, 1'b0);
        check("bub_occ0", 32'(occ0), 32'd2);
        check("bub_q0",   32'(q0),   32'hA5);
        check("bub_occ1", 32'(occ1), 32'd2);
        drain(4);

        // Simultaneous in/out on a full pipe.
        for (int i = 0; i < 5; i++) step(1'b1, 8'(8'h60 + i), 1'b0, 1'b0);
        step(1'b1, 8'h77, 1'b1, 1'b0);
        check("sim_occ0", 32'(occ0), 32'd3);
        check("sim_occ1", 32'(occ1), 32'd3);
        drain(6);

        // Flush with an input offered in the same cycle.
        for (int i = 0; i < 3; i++) step(1'b1, 8'(8'h80 + i), 1'b0, 1'b0);
        step(1'b1, 8'h99, 1'b0, 1'b1);
        check("fl_valid0", 32'(ovalid0), 32'd0);
        check("fl_occ0",   32'(occ0),    32'd0);
        check("fl_occ1",   32'(occ1),    32'd0);
        drain(5);

        // Asynchronous reset pulse between edges while streaming.
        for (int i = 1; i <= 8; i++) begin
            step(1'b1, 8'(i), 1'b1, 1'b0);
            if (i == 4) begin
                #2;
                rst = 1'b1;
                #1;
                check("ar_valid0", 32'(ovalid0), 32'd0);
                check("ar_q0",     32'(q0),      32'd0);
                check("ar_rdy0",   32'(iready0), 32'd1);
                check("ar_occ0",   32'(occ0),    32'd0);
                check("ar_valid1", 32'(ovalid1), 32'd0);
                check("ar_rdy1",   32'(iready1), 32'd1);
                check("ar_occ1",   32'(occ1),    32'd0);
                model_reset();
                #1;
                rst = 1'b0;
            end
        end
        drain(5);

        // Randomised traffic with occasional stalls and flushes.
        for (int i = 0; i < 400; i++) begin
            step($urandom_range(0, 3) != 0, 8'($urandom),
                 $urandom_range(0, 2) != 0, $urandom_range(0, 39) == 0);
        end
        drain(6);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule : tb_pipe_stages
